// File: rtl/trena_pkg.sv
// trena_pkg: shared state encoding and BCD helpers for the multi-sample trena path
package trena_pkg;
  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARA     = 4'd1,
    TRIGGER     = 4'd2,
    ESPERA_ECHO = 4'd3,
    MEDE        = 4'd4,
    ARMAZENA    = 4'd5,
    INTERVALO   = 4'd6,
    FINAL       = 4'd7,
    REPOUSO     = 4'd8
  } estado_t;
  function automatic logic [63:0] bcd_noves(input int digits);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < digits; i++) v = {v[59:0], 4'h9};
    return v;
  endfunction
endpackage

// File: rtl/contador_bcd_cm.sv
// contador_bcd_cm: echo-width prescaler feeding a saturating packed-BCD centimetre counter
module contador_bcd_cm import trena_pkg::*; #(
  parameter int DIGITS   = 3,
  parameter int TICKS_CM = 2941
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_clr,
  input  logic                  i_en,
  output logic [4*DIGITS-1:0]   o_bcd
);
  localparam int PW = TICKS_CM > 1 ? $clog2(TICKS_CM) : 1;
  localparam logic [PW-1:0] P_MAX = PW'(TICKS_CM - 1);
  localparam logic [4*DIGITS-1:0] NOVES = (4*DIGITS)'(bcd_noves(DIGITS));
  logic [PW-1:0]       r_pre;
  logic [4*DIGITS-1:0] w_inc;
  logic                w_c;
  always_comb begin
    w_inc = o_bcd;
    w_c   = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (w_c) begin
        w_inc[4*d+:4] = (o_bcd[4*d+:4] == 4'd9) ? 4'd0 : o_bcd[4*d+:4] + 4'd1;
        w_c           = (o_bcd[4*d+:4] == 4'd9);
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset || i_clr) begin
      r_pre <= '0;
      o_bcd <= '0;
    end else if (i_en) begin
      r_pre <= (r_pre == P_MAX) ? '0 : r_pre + 1'b1;
      if (r_pre == P_MAX && o_bcd != NOVES) o_bcd <= w_inc;
    end
  end
endmodule

// File: rtl/trena_medidor_multi.sv
// trena_medidor_multi: N-sample ultrasonic range measurement keeping the minimum valid sample
module trena_medidor_multi import trena_pkg::*; #(
  parameter int DIGITS           = 3,
  parameter int N_AMOSTRAS       = 4,
  parameter int TICKS_CM         = 2941,
  parameter int TRIGGER_CYCLES   = 500,
  parameter int TIMEOUT_CYCLES   = 1250000,
  parameter int INTERVALO_CYCLES = 3000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mensurar,
  input  logic                modo_continuo,
  input  logic                echo,
  output logic                trigger,
  output logic [4*DIGITS-1:0] medida,
  output logic                pronto,
  output logic                erro,
  output logic [3:0]          db_estado
);
  localparam int W = 4*DIGITS;
  localparam logic [W-1:0]  NOVES  = W'(bcd_noves(DIGITS));
  localparam logic [31:0]   TRIG_M1 = 32'(TRIGGER_CYCLES - 1);
  localparam logic [31:0]   TO_M1   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]   INT_M1  = 32'(INTERVALO_CYCLES - 1);
  localparam logic [31:0]   N_M1    = 32'(N_AMOSTRAS - 1);
  estado_t     r_estado, w_prox;
  logic        r_echo_m, r_echo_s, r_echo_p;
  logic [31:0] r_cnt, r_n;
  logic        r_valida, r_ok;
  logic [W-1:0] r_min, w_bcd;
  logic        w_borda, w_conta, w_to;
  assign w_borda   = r_echo_s & ~r_echo_p;
  assign w_to      = (r_cnt == TO_M1);
  // the rising-edge cycle itself is echo-high time, so it is counted too
  assign w_conta   = (r_estado == MEDE && r_echo_s) || (r_estado == ESPERA_ECHO && w_borda);
  assign pronto    = (r_estado == FINAL);
  assign db_estado = r_estado;
  contador_bcd_cm #(.DIGITS(DIGITS), .TICKS_CM(TICKS_CM)) u_cnt (
    .clock (clock),
    .reset (reset),
    .i_clr (r_estado == TRIGGER),
    .i_en  (w_conta),
    .o_bcd (w_bcd)
  );
  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      INICIAL:     w_prox = mensurar ? PREPARA : INICIAL;
      PREPARA:     w_prox = TRIGGER;
      TRIGGER:     w_prox = (r_cnt == TRIG_M1) ? ESPERA_ECHO : TRIGGER;
      ESPERA_ECHO: w_prox = w_borda ? MEDE : w_to ? ARMAZENA : ESPERA_ECHO;
      MEDE:        w_prox = (!r_echo_s || w_to) ? ARMAZENA : MEDE;
      ARMAZENA:    w_prox = (r_n == N_M1) ? FINAL : INTERVALO;
      INTERVALO:   w_prox = (r_cnt == INT_M1) ? TRIGGER : INTERVALO;
      FINAL:       w_prox = modo_continuo ? REPOUSO : INICIAL;
      REPOUSO:     w_prox = (r_cnt == INT_M1) ? PREPARA : REPOUSO;
      default:     w_prox = INICIAL;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= INICIAL;
      r_echo_m <= 1'b0;
      r_echo_s <= 1'b0;
      r_echo_p <= 1'b0;
      r_cnt    <= '0;
      r_n      <= '0;
      r_valida <= 1'b0;
      r_ok     <= 1'b0;
      r_min    <= '0;
      trigger  <= 1'b0;
      medida   <= '0;
      erro     <= 1'b0;
    end else begin
      r_estado <= w_prox;
      r_echo_m <= echo;
      r_echo_s <= r_echo_m;
      r_echo_p <= r_echo_s;
      trigger  <= (w_prox == TRIGGER);
      // timeout keeps running across the ESPERA_ECHO -> MEDE hand-off
      r_cnt    <= (w_prox != r_estado && w_prox != MEDE) ? '0 : r_cnt + 32'd1;
      if (r_estado == PREPARA) begin
        r_n   <= '0;
        r_min <= NOVES;
        r_ok  <= 1'b0;
      end
      if (r_estado == TRIGGER) r_valida <= 1'b0;
      if (r_estado == MEDE && !r_echo_s) r_valida <= 1'b1;
      if (r_estado == ARMAZENA) begin
        r_n <= r_n + 32'd1;
        // equality keeps a saturated all-9s sample valid without changing the minimum
        if (r_valida && w_bcd <= r_min) begin
          r_min <= w_bcd;
          r_ok  <= 1'b1;
        end
      end
      if (r_estado == FINAL) begin
        erro <= ~r_ok;
        if (r_ok) medida <= r_min;
      end
    end
  end
endmodule

// File: tb/tb_trena_medidor_multi.sv
// tb_trena_medidor_multi: directed checks of multi-sample measurement, timeout, saturation and continuous mode
module tb_trena_medidor_multi;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       reset, mensurar, modo, echo, trigger, pronto, erro;
  logic [11:0] medida;
  logic [3:0] db;
  logic       mens2, echo2, trig2, pronto2, erro2;
  logic [7:0] med2;
  logic [3:0] db2;
  int checks = 0, errors = 0, n_trig = 0;
  logic trig_d = 1'b0;
  trena_medidor_multi #(.DIGITS(3), .N_AMOSTRAS(4), .TICKS_CM(4), .TRIGGER_CYCLES(5),
                        .TIMEOUT_CYCLES(2000), .INTERVALO_CYCLES(20)) dut (
    .clock(clk), .reset(reset), .mensurar(mensurar), .modo_continuo(modo), .echo(echo),
    .trigger(trigger), .medida(medida), .pronto(pronto), .erro(erro), .db_estado(db));
  trena_medidor_multi #(.DIGITS(2), .N_AMOSTRAS(1), .TICKS_CM(4), .TRIGGER_CYCLES(5),
                        .TIMEOUT_CYCLES(2000), .INTERVALO_CYCLES(20)) dut2 (
    .clock(clk), .reset(reset), .mensurar(mens2), .modo_continuo(1'b0), .echo(echo2),
    .trigger(trig2), .medida(med2), .pronto(pronto2), .erro(erro2), .db_estado(db2));
  always @(negedge clk) begin
    if (trigger && !trig_d) n_trig++;
    trig_d = trigger;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic inicia();
    mensurar = 1'b1;
    tick(1);
    mensurar = 1'b0;
  endtask
  task automatic amostra(input int w);
    int t = 0, len = 0;
    while (!trigger && t < 5000) begin tick(1); t++; end
    check("trig_seen", {31'b0, trigger}, 1);
    while (trigger && len < 100) begin tick(1); len++; end
    check("trig_len", len, 5);
    if (w > 0) begin
      tick(3);
      echo = 1'b1;
      tick(w);
      echo = 1'b0;
    end
  endtask
  task automatic espera_pronto(input string tag, input logic [11:0] em, input logic ee);
    int t = 0;
    while (!pronto && t < 10000) begin tick(1); t++; end
    check({tag, "_pronto"}, {31'b0, pronto}, 1);
    tick(1);
    check({tag, "_pulso"}, {31'b0, pronto}, 0);
    tick(1);
    check({tag, "_medida"}, {20'b0, medida}, {20'b0, em});
    check({tag, "_erro"}, {31'b0, erro}, {31'b0, ee});
  endtask
  task automatic medicao(input string tag, input int w0, input int w1, input int w2, input int w3,
                         input logic [11:0] em, input logic ee);
    int n0 = n_trig;
    amostra(w0);
    amostra(w1);
    amostra(w2);
    amostra(w3);
    espera_pronto(tag, em, ee);
    check({tag, "_ntrig"}, n_trig - n0, 4);
  endtask
  initial begin
    int t, np;
    reset = 1'b1; mensurar = 1'b0; modo = 1'b0; echo = 1'b0; mens2 = 1'b0; echo2 = 1'b0;
    tick(3);
    check("rst_trigger", {31'b0, trigger}, 0);
    check("rst_medida", {20'b0, medida}, 0);
    check("rst_pronto", {31'b0, pronto}, 0);
    check("rst_erro", {31'b0, erro}, 0);
    check("rst_estado", {28'b0, db}, 0);
    reset = 1'b0;
    tick(2);
    inicia(); medicao("t2", 492, 492, 492, 492, 12'h123, 1'b0);
    check("t2_estado", {28'b0, db}, 0);
    inicia(); medicao("t3", 52, 33, 47, 61, 12'h008, 1'b0);
    inicia(); medicao("t4a", 0, 0, 0, 0, 12'h008, 1'b1);
    inicia(); medicao("t4b", 40, 44, 48, 0, 12'h010, 1'b0);
    mens2 = 1'b1; tick(1); mens2 = 1'b0;
    t = 0; while (!trig2 && t < 5000) begin tick(1); t++; end
    check("t5_trig", {31'b0, trig2}, 1);
    t = 0; while (trig2 && t < 100) begin tick(1); t++; end
    tick(3); echo2 = 1'b1; tick(420); echo2 = 1'b0;
    t = 0; while (!pronto2 && t < 5000) begin tick(1); t++; end
    check("t5_pronto", {31'b0, pronto2}, 1);
    tick(2);
    check("t5_sat", {24'b0, med2}, 32'h99);
    check("t5_erro", {31'b0, erro2}, 0);
    echo2 = 1'b1; tick(5);
    mens2 = 1'b1; tick(1); mens2 = 1'b0;
    t = 0; while (!pronto2 && t < 5000) begin tick(1); t++; end
    check("t5_to_pronto", {31'b0, pronto2}, 1);
    tick(2);
    check("t5_to_erro", {31'b0, erro2}, 1);
    check("t5_to_medida", {24'b0, med2}, 32'h99);
    echo2 = 1'b0;
    modo = 1'b1;
    inicia();
    for (int k = 0; k < 2; k++) medicao("t6", 20, 20, 20, 20, 12'h005, 1'b0);
    modo = 1'b0;
    amostra(0);
    tick(3); echo = 1'b1;
    t = 0; while (db != 4'd4 && t < 200) begin tick(1); t++; end
    check("t6_mede", {28'b0, db}, 4);
    reset = 1'b1; tick(1);
    check("t6_rst_estado", {28'b0, db}, 0);
    check("t6_rst_trigger", {31'b0, trigger}, 0);
    check("t6_rst_pronto", {31'b0, pronto}, 0);
    check("t6_rst_medida", {20'b0, medida}, 0);
    reset = 1'b0; echo = 1'b0;
    np = 0;
    repeat (100) begin tick(1); np += int'(pronto); end
    check("t6_no_pronto", np, 0);
    check("t6_idle", {28'b0, db}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
